inst_loader: RTL

- Writer side of the processor's instruction fetch interface. The processor drives `address[2:0]` and reads `instruction[7:0]`; this block is what fills and serves that store.
- Accepts a framed byte stream (length, payload, XOR checksum) on a valid/ready port and writes the payload into an 8-entry instruction store.
- Serves `instruction` to the processor and asserts `run` only after a complete, checksum-verified load.

---
 rtl/inst_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Purpose:
//   Writer side of the processor's instruction fetch interface. A framed byte
//   stream arrives on a valid/ready port in three parts: a length byte L, then
//   L payload bytes, then one checksum byte equal to the XOR of the payload.
//   The payload is written into a small instruction store. The processor reads
//   that store through `address`/`instruction`. `run` is raised only after a
//   complete load whose checksum matched.
//
// Ports:
//   clk          in   1         system clock, rising-edge active
//   reset        in   1         synchronous, active-high reset
//   load_start   in   1         one-cycle request to begin/restart a load
//   in_valid     in   1         stream byte valid
//   in_data      in   DATA_W    stream byte
//   in_ready     out  1         byte accepted this cycle when in_valid is high
//   address      in   ADDR_W    processor fetch address
//   instruction  out  DATA_W    store[address] while running, else zero
//   run          out  1         program valid, processor may execute
//   load_count   out  ADDR_W+1  payload length of the last successful load
//   done         out  1         one-cycle pulse after a successful load
//   error        out  1         sticky, the last load was rejected
// ---------------------------------------------------------------------------
module inst_loader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              run,
  output logic [ADDR_W:0]   load_count,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The largest legal length, expressed at stream-byte width so that a
  // length byte with any upper bits set compares as too large.
  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [DATA_W-1:0] store [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] acc;

  logic xfer;
  logic len_ok;
  logic last_byte;
  logic chk_ok;

  // in_ready is withheld during a load_start cycle. The restart wins, and
  // because the source sees no handshake, the byte it offered is not lost.
  assign in_ready = ((state == S_LEN) || (state == S_DATA) || (state == S_CHK))
                    && !load_start;
  assign xfer     = in_valid && in_ready;

  assign len_ok    = (in_data != '0) && (in_data <= MAX_LEN);
  assign last_byte = ({1'b0, wr_ptr} == (len - (ADDR_W + 1)'(1)));
  assign chk_ok    = (in_data == acc);

  // run is just the RUN state. It drops on the cycle after a load_start,
  // because the state has moved to LEN by then.
  assign run = (state == S_RUN);

  // Entries beyond the loaded length read back as zero. load_start clears the
  // store, so no extra masking against len is needed.
  assign instruction = run ? store[address] : '0;

  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = S_LEN;
    end else if (xfer) begin
      case (state)
        S_LEN:   state_next = len_ok ? S_DATA : S_IDLE;
        S_DATA:  if (last_byte) state_next = S_CHK;
        S_CHK:   state_next = chk_ok ? S_RUN : S_IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame bookkeeping. wr_ptr stops at L-1 on the last payload byte, so it
  // never wraps. It is reset on the next load_start anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      acc    <= '0;
      len    <= '0;
    end else if (load_start) begin
      wr_ptr <= '0;
      acc    <= '0;
    end else if (xfer) begin
      case (state)
        S_LEN: begin
          if (len_ok) len <= in_data[ADDR_W:0];
        end
        S_DATA: begin
          acc <= acc ^ in_data;
          if (!last_byte) wr_ptr <= wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Instruction store. It is cleared on reset and on every load_start, so a
  // short program never exposes bytes from an earlier, longer one.
  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (xfer && (state == S_DATA)) begin
      store[wr_ptr] <= in_data;
    end
  end

  // Status flags. done is a single-cycle pulse. error is sticky until the
  // next load_start. Both are set only on a checksum or length outcome, and
  // those outcomes are exclusive, so done and error are never high together.
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      error      <= 1'b0;
      load_count <= '0;
    end else begin
      done <= 1'b0;
      if (load_start) begin
        error <= 1'b0;
      end else if (xfer) begin
        case (state)
          S_LEN: begin
            if (!len_ok) error <= 1'b1;
          end
          S_CHK: begin
            if (chk_ok) begin
              done       <= 1'b1;
              load_count <= len;
            end else begin
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
